ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- Decode/execute pipeline register that feeds the ALU.
- Captures a fetched ARM data-processing instruction and its register-file read data.
- Builds the shifted operand2 (barrel shifter plus shifter carry-out) and registers the ALU-facing fields: instruction_codes, opcode, a, b, cond, s_bit.
- Supports hazard stall and branch flush.

Parameters:
- DATA_W, 32, datapath width (only 32 supported).
- NOP_COND, 4'b1111, condition code driven on bubbles (never-execute).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  inst and operands are valid this cycle.
- stall  input  1  hold all output registers.
- flush  input  1  replace stage contents with a bubble.
- inst  input  32  instruction word.
- rn_data  input  32  Rn read data.
- rm_data  input  32  Rm read data.
- rs_data  input  32  Rs read data (register-specified shift amount).
- c_in  input  1  current CPSR C flag.
- valid  output  1  stage holds a real instruction.
- instruction_codes  output  3  inst[27:25].
- opcode  output  4  inst[24:21].
- cond  output  4  inst[31:28], or NOP_COND on a bubble.
- s_bit  output  1  inst[20], forced 0 on a bubble.
- a  output  32  rn_data.
- b  output  32  shifted operand2.
- shift_carry  output  1  shifter carry-out.
- rd  output  4  inst[15:12].
- illegal  output  1  unsupported encoding captured.

Behaviour:
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Update priority per edge: reset > flush > stall > load.
- Reset and flush both load a bubble:
  - valid=0, cond=NOP_COND, s_bit=0, illegal=0.
  - All other outputs 0.
- Flush asserted together with stall produces a bubble; flush wins.
- Stall (without flush) holds every output register unchanged, including valid.
- Load with in_valid=0 loads a bubble. Load with in_valid=1 loads valid=1 and the decoded fields.
- Immediate operand2 (inst[25]=1):
  - b = imm8 zero-extended, rotated right by 2*rot (imm8 = inst[7:0], rot = inst[11:8]).
  - shift_carry = c_in if rot==0, else b[31].
- Immediate shift (inst[25]=0, inst[4]=0); amt = inst[11:7], type = inst[6:5]:
  - LSL: amt 0 gives b=rm, carry=c_in. Otherwise b=rm<<amt, carry=rm[32-amt].
  - LSR: amt 0 means shift by 32, giving b=0, carry=rm[31]. Otherwise logical shift, carry=rm[amt-1].
  - ASR: amt 0 means shift by 32, giving b = rm[31] replicated, carry=rm[31]. Otherwise arithmetic shift, carry=rm[amt-1].
  - ROR: amt 0 means RRX, giving b={c_in, rm[31:1]}, carry=rm[0]. Otherwise rotate, carry=rm[amt-1].
- Register shift (inst[25]=0, inst[4]=1, inst[7]=0): amt = rs_data[7:0]; see Optional Feature.
- inst[25]=0, inst[4]=1, inst[7]=1 (multiply/extra load-store space): illegal=1, valid=1, b=rm, carry=c_in.
- Non-data-processing instruction_codes (not 000/001): fields pass through unchanged and b is computed by the same rules. The consumer ignores b for these.
- Outputs are registered only. No combinational path from inputs to outputs.

Optional Feature:
- Macro REG_SHIFT_EN.
- Defined: register-specified shifts are supported.
  - amt 0: b=rm, carry=c_in.
  - LSL: 1..31 normal; 32 gives b=0, carry=rm[0]; >32 gives b=0, carry=0.
  - LSR: 32 gives b=0, carry=rm[31]; >32 gives b=0, carry=0.
  - ASR: >=32 gives sign fill, carry=rm[31].
  - ROR: if amt[4:0]==0 (amt nonzero), b=rm, carry=rm[31]; else rotate by amt[4:0].
- Undefined: rs_data is ignored. Register-shift encodings load illegal=1, valid=1, b=rm, shift_carry=c_in.

Test Plan:
- Immediate rotate: inst=0xE3A004FF (MOV r0,#0xFF ror 8), c_in=0 -> next cycle b=0xFF000000, shift_carry=1, opcode=4'b1101, cond=4'b1110, rd=0, valid=1.
- LSR #0 special case: inst=0xE1B01021, rm_data=0x80000001, c_in=0 -> b=0x00000000, shift_carry=1. Same with ROR #0 (RRX, inst=0xE1B01061) and c_in=1 -> b=0xC0000000, shift_carry=1.
- Stall hold: load ADD, then stall=1 for 3 cycles while inst changes -> all outputs unchanged. Deassert stall -> new instruction appears one cycle later.
- Flush vs. stall: stall=1 and flush=1 in the same cycle -> valid=0, cond=4'b1111, s_bit=0.
- Reset mid-operation: reset=1 while valid=1 and stall=1 -> next edge gives the bubble reset state. in_valid=0 after reset keeps valid=0.
- Register shift: inst=0xE1A00312 (LSL r2 by r3), rs_data=0x21, rm_data=0xFFFFFFFF -> with REG_SHIFT_EN: b=0, shift_carry=0, illegal=0. Without it: illegal=1, b=0xFFFFFFFF.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: decode/execute pipeline register in front of the ALU.
// Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N.
// Backpressure: stall holds every output register; flush (or reset) loads a bubble.
//
// Builds the ARM data-processing operand2 (barrel shifter and shifter carry-out)
// and registers the ALU-facing fields of the captured instruction.
//
// Optional feature macro: REG_SHIFT_EN
//   defined   - register-specified shifts (amount from rs_data[7:0]) are executed.
//   undefined - register-shift encodings are flagged illegal and rs_data is ignored.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   in_valid            inst and operands are valid this cycle
//   stall, flush        hold all outputs / replace contents with a bubble
//   inst                instruction word
//   rn_data, rm_data    register-file read data for Rn and Rm
//   rs_data             register-file read data for Rs (shift amount)
//   c_in                current CPSR C flag
//   valid               stage holds a real instruction
//   instruction_codes   inst[27:25]
//   opcode              inst[24:21]
//   cond                inst[31:28], NOP_COND on a bubble
//   s_bit               inst[20], 0 on a bubble
//   a                   Rn operand
//   b                   shifted operand2
//   shift_carry         shifter carry-out
//   rd                  inst[15:12]
//   illegal             unsupported encoding captured

module ex_operand_stage #(
  // Only 32 is supported; the shifter arithmetic below is written for 32 bits.
  parameter int         DATA_W   = 32,
  parameter logic [3:0] NOP_COND = 4'b1111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rn_data,
  input  logic [DATA_W-1:0] rm_data,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              c_in,
  output logic              valid,
  output logic [2:0]        instruction_codes,
  output logic [3:0]        opcode,
  output logic [3:0]        cond,
  output logic              s_bit,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              shift_carry,
  output logic [3:0]        rd,
  output logic              illegal
);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Rn index is resolved by the register file upstream; rs_data is only
  // partly consumed (or not at all without register shifts).
  logic unused_bits;
  assign unused_bits = ^{inst[19:16], rs_data};

  // Rotated 8-bit immediate. Returns {carry, value}.
  function automatic logic [32:0] rot_imm(input logic [11:0] f, input logic cin);
    logic [63:0] d;
    logic [31:0] r;
    d = {24'b0, f[7:0], 24'b0, f[7:0]} >> {f[11:8], 1'b0};
    r = d[31:0];
    // A zero rotation leaves the carry flag untouched.
    rot_imm = {((f[11:8] == 4'd0) ? cin : r[31]), r};
  endfunction

  // Shift by a nonzero amount 1..31. Returns {carry, value}.
  // The extra guard bit on each side catches the last bit shifted out.
  function automatic logic [32:0] shift_1_31(input logic [31:0] rm, input logic [1:0] ty,
                                             input logic [4:0] amt);
    logic [32:0] t;
    logic [63:0] d;
    t = '0;
    d = '0;
    case (ty)
      SH_LSL: begin
        t = {1'b0, rm} << amt;
        shift_1_31 = t;
      end
      SH_LSR: begin
        t = {rm, 1'b0} >> amt;
        shift_1_31 = {t[0], t[32:1]};
      end
      SH_ASR: begin
        t = 33'($signed({rm, 1'b0}) >>> amt);
        shift_1_31 = {t[0], t[32:1]};
      end
      default: begin
        d = {rm, rm} >> amt;
        // Last bit rotated out lands in bit 31.
        shift_1_31 = {d[31], d[31:0]};
      end
    endcase
  endfunction

  // Immediate-amount shift. A zero amount encodes LSL #0, LSR #32, ASR #32, RRX.
  function automatic logic [32:0] shift_by_imm(input logic [31:0] rm, input logic [1:0] ty,
                                               input logic [4:0] amt, input logic cin);
    if (amt != 5'd0) begin
      shift_by_imm = shift_1_31(rm, ty, amt);
    end else begin
      case (ty)
        SH_LSL:  shift_by_imm = {cin, rm};
        SH_LSR:  shift_by_imm = {rm[31], 32'b0};
        SH_ASR:  shift_by_imm = {rm[31], {32{rm[31]}}};
        default: shift_by_imm = {rm[0], cin, rm[31:1]};
      endcase
    end
  endfunction

`ifdef REG_SHIFT_EN
  // Register-amount shift, amount taken from Rs[7:0] (0..255).
  function automatic logic [32:0] shift_by_reg(input logic [31:0] rm, input logic [1:0] ty,
                                               input logic [7:0] amt, input logic cin);
    shift_by_reg = {cin, rm};
    if (amt != 8'd0) begin
      case (ty)
        SH_LSL: begin
          if (amt < 8'd32)       shift_by_reg = shift_1_31(rm, ty, amt[4:0]);
          else if (amt == 8'd32) shift_by_reg = {rm[0], 32'b0};
          else                   shift_by_reg = 33'b0;
        end
        SH_LSR: begin
          if (amt < 8'd32)       shift_by_reg = shift_1_31(rm, ty, amt[4:0]);
          else if (amt == 8'd32) shift_by_reg = {rm[31], 32'b0};
          else                   shift_by_reg = 33'b0;
        end
        SH_ASR: begin
          if (amt < 8'd32) shift_by_reg = shift_1_31(rm, ty, amt[4:0]);
          else             shift_by_reg = {rm[31], {32{rm[31]}}};
        end
        default: begin
          // Rotation by a nonzero multiple of 32 returns rm with carry = bit 31.
          if (amt[4:0] == 5'd0) shift_by_reg = {rm[31], rm};
          else                  shift_by_reg = shift_1_31(rm, ty, amt[4:0]);
        end
      endcase
    end
  endfunction
`endif

  // Operand2 next-state. Fallback (illegal encodings) passes rm and c_in.
  logic [31:0] b_nxt;
  logic        carry_nxt;
  logic        illegal_nxt;

  always_comb begin
    b_nxt       = rm_data;
    carry_nxt   = c_in;
    illegal_nxt = 1'b0;
    if (inst[25]) begin
      {carry_nxt, b_nxt} = rot_imm(inst[11:0], c_in);
    end else if (!inst[4]) begin
      {carry_nxt, b_nxt} = shift_by_imm(rm_data, inst[6:5], inst[11:7], c_in);
    end else if (inst[7]) begin
      // Multiply / extra load-store space is not handled by this stage.
      illegal_nxt = 1'b1;
    end else begin
`ifdef REG_SHIFT_EN
      {carry_nxt, b_nxt} = shift_by_reg(rm_data, inst[6:5], rs_data[7:0], c_in);
`else
      illegal_nxt = 1'b1;
`endif
    end
  end

  // A bubble is loaded on reset, flush (even when stalled) and on an
  // unstalled cycle with no valid input; stall alone holds everything.
  logic load_bubble;
  assign load_bubble = reset || flush || (!stall && !in_valid);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      valid             <= 1'b0;
      instruction_codes <= 3'b000;
      opcode            <= 4'b0000;
      cond              <= NOP_COND;
      s_bit             <= 1'b0;
      a                 <= '0;
      b                 <= '0;
      shift_carry       <= 1'b0;
      rd                <= 4'b0000;
      illegal           <= 1'b0;
    end else if (!stall) begin
      valid             <= 1'b1;
      instruction_codes <= inst[27:25];
      opcode            <= inst[24:21];
      cond              <= inst[31:28];
      s_bit             <= inst[20];
      a                 <= rn_data;
      b                 <= b_nxt;
      shift_carry       <= carry_nxt;
      rd                <= inst[15:12];
      illegal           <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, c_in;
  logic [31:0] inst, rn_data, rm_data, rs_data;
  logic        valid, s_bit, shift_carry, illegal;
  logic [2:0]  instruction_codes;
  logic [3:0]  opcode, cond, rd;
  logic [31:0] a, b;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .inst(inst), .rn_data(rn_data), .rm_data(rm_data), .rs_data(rs_data), .c_in(c_in),
    .valid(valid), .instruction_codes(instruction_codes), .opcode(opcode), .cond(cond),
    .s_bit(s_bit), .a(a), .b(b), .shift_carry(shift_carry), .rd(rd), .illegal(illegal)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        valid;
    logic [2:0]  codes;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [3:0]  rd;
    logic        ill;
  } out_t;

  typedef struct {
    string       nm;
    logic        rst, iv, st, fl;
    logic [31:0] inst, rn, rm, rs;
    logic        cin;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t bubble();
    out_t o;
    o = '0;
    o.cond = 4'b1111;
    return o;
  endfunction

  // Expected output for a loaded instruction with hand-computed operand2.
  function automatic out_t exp_ld(input logic [31:0] i, input logic [31:0] rn,
                                  input logic [31:0] bv, input logic cv, input logic il);
    out_t o;
    o = '0;
    o.valid = 1'b1; o.codes = i[27:25]; o.opcode = i[24:21]; o.cond = i[31:28];
    o.s = i[20]; o.a = rn; o.b = bv; o.c = cv; o.rd = i[15:12]; o.ill = il;
    return o;
  endfunction

  // Reference shifter: moves one bit at a time, carry = last bit moved out.
  // ty: 0 LSL, 1 LSR, 2 ASR, 3 ROR. n = 0 leaves value and carry-in unchanged.
  function automatic logic [32:0] shift_n(input logic [31:0] v0, input logic [1:0] ty,
                                          input int n, input logic cin);
    logic [31:0] v;
    logic        c;
    v = v0;
    c = cin;
    for (int i = 0; i < n; i++) begin
      case (ty)
        2'd0: begin c = v[31]; v = {v[30:0], 1'b0}; end
        2'd1: begin c = v[0];  v = {1'b0, v[31:1]}; end
        2'd2: begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  function automatic out_t model_load(input logic [31:0] i, input logic [31:0] rn,
                                      input logic [31:0] rm, input logic [31:0] rs,
                                      input logic cin);
    out_t        o;
    logic [32:0] r;
    int          n;
    o = exp_ld(i, rn, 32'd0, 1'b0, 1'b0);
    r = {cin, rm};
    if (i[25]) begin
      // Rotating one bit at a time leaves carry = new bit 31, or cin if rot is 0.
      r = shift_n({24'd0, i[7:0]}, 2'd3, 2 * int'(i[11:8]), cin);
    end else if (i[4] && i[7]) begin
      o.ill = 1'b1;
    end else if (i[4]) begin
`ifdef REG_SHIFT_EN
      r = shift_n(rm, i[6:5], int'(rs[7:0]), cin);
`else
      o.ill = 1'b1;
`endif
    end else begin
      n = int'(i[11:7]);
      if (n != 0)            r = shift_n(rm, i[6:5], n, cin);
      else if (i[6:5] == 0)  r = {cin, rm};
      else if (i[6:5] == 3)  r = {rm[0], cin, rm[31:1]};
      else                   r = shift_n(rm, i[6:5], 32, cin);
    end
    o.b = r[31:0];
    o.c = r[32];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input out_t e);
    chk({tag, ".valid"},  32'(valid),             32'(e.valid));
    chk({tag, ".codes"},  32'(instruction_codes), 32'(e.codes));
    chk({tag, ".opcode"}, 32'(opcode),            32'(e.opcode));
    chk({tag, ".cond"},   32'(cond),              32'(e.cond));
    chk({tag, ".s_bit"},  32'(s_bit),             32'(e.s));
    chk({tag, ".a"},      a,                      e.a);
    chk({tag, ".b"},      b,                      e.b);
    chk({tag, ".carry"},  32'(shift_carry),       32'(e.c));
    chk({tag, ".rd"},     32'(rd),                32'(e.rd));
    chk({tag, ".illegal"},32'(illegal),           32'(e.ill));
  endtask

  // Drive one cycle of inputs, then sample just after the edge that captures them.
  task automatic apply(input logic r, input logic iv, input logic st, input logic fl,
                       input logic [31:0] i, input logic [31:0] rn, input logic [31:0] rm,
                       input logic [31:0] rs, input logic ci);
    reset = r; in_valid = iv; stall = st; flush = fl;
    inst = i; rn_data = rn; rm_data = rm; rs_data = rs; c_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string nm, input logic r, input logic iv, input logic st,
                         input logic fl, input logic [31:0] i, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [31:0] rs, input logic ci,
                         input out_t e);
    vec_t v;
    v.nm = nm; v.rst = r; v.iv = iv; v.st = st; v.fl = fl;
    v.inst = i; v.rn = rn; v.rm = rm; v.rs = rs; v.cin = ci; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    out_t cur, e_add, nxt;
    logic r, iv, st, fl, ci;
    logic [31:0] i, rn, rm, rs;

    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    inst = '0; rn_data = '0; rm_data = '0; rs_data = '0; c_in = 1'b0;

    // ---- table-driven vectors (applied back-to-back, one edge each) ----
    add_vec("reset", 1, 1, 0, 0, 32'hE3A004FF, 32'h1, 32'h2, 32'h0, 0, bubble());
    add_vec("imm_rot8", 0, 1, 0, 0, 32'hE3A004FF, 32'h11111111, 32'h0, 32'h0, 0,
            exp_ld(32'hE3A004FF, 32'h11111111, 32'hFF000000, 1, 0));
    add_vec("lsr0", 0, 1, 0, 0, 32'hE1B01021, 32'h0, 32'h80000001, 32'h0, 0,
            exp_ld(32'hE1B01021, 32'h0, 32'h00000000, 1, 0));
    add_vec("rrx", 0, 1, 0, 0, 32'hE1B01061, 32'h0, 32'h80000001, 32'h0, 1,
            exp_ld(32'hE1B01061, 32'h0, 32'hC0000000, 1, 0));
    add_vec("lsl5", 0, 1, 0, 0, 32'hE1A00281, 32'h5, 32'h08000001, 32'h0, 0,
            exp_ld(32'hE1A00281, 32'h5, 32'h00000020, 1, 0));
    add_vec("asr0", 0, 1, 0, 0, 32'hE1A00041, 32'h6, 32'h80000000, 32'h0, 0,
            exp_ld(32'hE1A00041, 32'h6, 32'hFFFFFFFF, 1, 0));
`ifdef REG_SHIFT_EN
    add_vec("regshift", 0, 1, 0, 0, 32'hE1A00312, 32'h7, 32'hFFFFFFFF, 32'h21, 1,
            exp_ld(32'hE1A00312, 32'h7, 32'h00000000, 0, 0));
`else
    add_vec("regshift", 0, 1, 0, 0, 32'hE1A00312, 32'h7, 32'hFFFFFFFF, 32'h21, 1,
            exp_ld(32'hE1A00312, 32'h7, 32'hFFFFFFFF, 1, 1));
`endif
    add_vec("mul_space", 0, 1, 0, 0, 32'hE0000091, 32'h8, 32'h00001234, 32'h5, 1,
            exp_ld(32'hE0000091, 32'h8, 32'h00001234, 1, 1));
    add_vec("imm_rot0", 0, 1, 0, 0, 32'hE3A000FF, 32'h9, 32'h0, 32'h0, 1,
            exp_ld(32'hE3A000FF, 32'h9, 32'h000000FF, 1, 0));
    add_vec("idle", 0, 0, 0, 0, 32'hE3A000FF, 32'h9, 32'h0, 32'h0, 1, bubble());
    add_vec("imm_rot2", 0, 1, 0, 0, 32'hE3A001FF, 32'hDEAD, 32'h0, 32'h0, 0,
            exp_ld(32'hE3A001FF, 32'hDEAD, 32'hC000003F, 1, 0));
    add_vec("flush_stall", 0, 1, 1, 1, 32'hE3A004FF, 32'h1, 32'h1, 32'h0, 1, bubble());

    foreach (tbl[k]) begin
      apply(tbl[k].rst, tbl[k].iv, tbl[k].st, tbl[k].fl, tbl[k].inst,
            tbl[k].rn, tbl[k].rm, tbl[k].rs, tbl[k].cin);
      chk_all(tbl[k].nm, tbl[k].exp);
    end

    // ---- stall hold: ADD r2,r1,r3 then 3 stalled cycles with changing inputs ----
    e_add = exp_ld(32'hE0812003, 32'd5, 32'd7, 1'b0, 1'b0);
    apply(0, 1, 0, 0, 32'hE0812003, 32'd5, 32'd7, 32'd0, 0);
    chk_all("add_load", e_add);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1'($urandom), 1, 0, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
      chk_all("stall_hold", e_add);
    end
    apply(0, 1, 0, 0, 32'hE1B01021, 32'h0, 32'h80000001, 32'h0, 0);
    chk_all("stall_release", exp_ld(32'hE1B01021, 32'h0, 32'h0, 1, 0));

    // ---- reset while valid and stalled ----
    apply(0, 1, 0, 0, 32'hE0812003, 32'd5, 32'd7, 32'd0, 0);
    chk_all("pre_reset", e_add);
    apply(1, 1, 1, 0, 32'hE3A004FF, 32'd1, 32'd2, 32'd0, 1);
    chk_all("reset_mid", bubble());
    apply(0, 0, 0, 0, 32'hE3A004FF, 32'd1, 32'd2, 32'd0, 1);
    chk_all("post_reset_idle", bubble());

    // ---- randomized traffic against the reference model ----
    cur = bubble();
    for (int k = 0; k < 500; k++) begin
      r  = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 3) == 0);
      iv = ($urandom_range(0, 4) != 0);
      ci = 1'($urandom);
      i  = $urandom;
      rn = $urandom;
      rm = ($urandom_range(0, 3) == 0) ? 32'h80000000 | $urandom_range(0, 15) : $urandom;
      rs = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (r || fl)   nxt = bubble();
      else if (st)   nxt = cur;
      else if (iv)   nxt = model_load(i, rn, rm, rs, ci);
      else           nxt = bubble();
      apply(r, iv, st, fl, i, rn, rm, rs, ci);
      cur = nxt;
      chk_all("rnd", cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
